// File: rtl/reg_spill_fill.sv
// reg_spill_fill: bulk copy of the register file to/from data memory.
// Optional RSF_CHECKSUM_EN adds a Checksum port summing transferred words.
module reg_spill_fill #(
  parameter int W = 8,
  parameter int A = 2,
  parameter int M = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Dir,
  input  logic [M-1:0] BaseAddr,
  output logic [A-1:0] RfRaddr,
  input  logic [W-1:0] RfDataOut,
  output logic         RfWriteEn,
  output logic [A-1:0] RfWaddr,
  output logic [W-1:0] RfDataIn,
  output logic [M-1:0] MemAddr,
  output logic         MemWriteEn,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut,
  output logic         Busy,
  output logic         Done
`ifdef RSF_CHECKSUM_EN
  ,
  output logic [W-1:0] Checksum
`endif
);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  localparam logic [A-1:0] LAST = '1;

  state_t       state;
  logic [A-1:0] index;
  logic         dir_q;
  logic [M-1:0] base_q;
  logic         done_q;

  logic xfer;
  logic spill;
  logic fill;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      index  <= '0;
      dir_q  <= 1'b0;
      base_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state  <= XFER;
            dir_q  <= Dir;
            base_q <= BaseAddr;
            index  <= '0;
          end
        end
        XFER: begin
          if (index == LAST) begin
            state  <= IDLE;
            index  <= '0;
            done_q <= 1'b1;
          end else begin
            index <= index + 1'b1;
          end
        end
      endcase
    end
  end

  assign xfer  = (state == XFER);
  assign spill = xfer && !dir_q;
  assign fill  = xfer && dir_q;

  assign Busy = xfer;
  assign Done = done_q;

  // Memory address wraps naturally at 2**M.
  assign MemAddr    = xfer ? base_q + M'(index) : '0;
  assign RfRaddr    = spill ? index : '0;
  assign MemDataIn  = spill ? RfDataOut : '0;
  assign MemWriteEn = spill;
  assign RfWaddr    = fill ? index : '0;
  assign RfDataIn   = fill ? MemDataOut : '0;
  assign RfWriteEn  = fill;

`ifdef RSF_CHECKSUM_EN
  logic [W-1:0] sum_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sum_q <= '0;
    end else if (state == IDLE && Start) begin
      sum_q <= '0;
    end else if (xfer) begin
      // Only one of the two data outputs is non-zero per cycle.
      sum_q <= sum_q + MemDataIn + RfDataIn;
    end
  end

  assign Checksum = sum_q;
`endif

endmodule

// File: tb/tb_reg_spill_fill.sv
// Self-checking bench for reg_spill_fill with reference memory/regfile model.
// Define RSF_CHECKSUM_EN to also check the Checksum port.
module tb_reg_spill_fill;
  localparam int W = 8;
  localparam int A = 2;
  localparam int M = 8;
  localparam int N = 4;
  localparam int D = 256;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Dir;
  logic [M-1:0] BaseAddr;
  logic [A-1:0] RfRaddr;
  logic [W-1:0] RfDataOut;
  logic         RfWriteEn;
  logic [A-1:0] RfWaddr;
  logic [W-1:0] RfDataIn;
  logic [M-1:0] MemAddr;
  logic         MemWriteEn;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;
  logic         Busy;
  logic         Done;
`ifdef RSF_CHECKSUM_EN
  logic [W-1:0] Checksum;
`endif

  logic [W-1:0] rf      [N];
  logic [W-1:0] mem     [D];
  logic [W-1:0] exp_rf  [N];
  logic [W-1:0] exp_mem [D];

  int checks   = 0;
  int failures = 0;

  reg_spill_fill #(.W(W), .A(A), .M(M)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Dir       (Dir),
    .BaseAddr  (BaseAddr),
    .RfRaddr   (RfRaddr),
    .RfDataOut (RfDataOut),
    .RfWriteEn (RfWriteEn),
    .RfWaddr   (RfWaddr),
    .RfDataIn  (RfDataIn),
    .MemAddr   (MemAddr),
    .MemWriteEn(MemWriteEn),
    .MemDataIn (MemDataIn),
    .MemDataOut(MemDataOut),
    .Busy      (Busy),
    .Done      (Done)
`ifdef RSF_CHECKSUM_EN
    ,
    .Checksum  (Checksum)
`endif
  );

  always #5 Clk = ~Clk;

  assign RfDataOut  = rf[RfRaddr];
  assign MemDataOut = mem[MemAddr];

  always @(posedge Clk) begin
    if (RfWriteEn === 1'b1) rf[RfWaddr] = RfDataIn;
    if (MemWriteEn === 1'b1) mem[MemAddr] = MemDataIn;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_images(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (rf[i] !== exp_rf[i]) bad++;
    for (int i = 0; i < D; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk({tag, "_image"}, bad, 0);
  endtask

  // Runs one transfer from cycle 0. poke: cycle with a stray Start.
  // chain: return at the Done cycle with the next Start already driven.
  task automatic do_op(input string tag, input logic d,
                       input logic [M-1:0] b, input int poke,
                       input bit chain, input logic nd,
                       input logic [M-1:0] nb);
    int done_cyc, busy_cnt, bad, last;
    logic [M-1:0] a;
    logic [W-1:0] sum;
    logic [W-1:0] cs;
    sum = '0;
    cs = '0;
    for (int i = 0; i < N; i++) begin
      a = b + M'(i);
      if (d) begin
        exp_rf[i] = mem[a];
        sum += mem[a];
      end else begin
        exp_mem[a] = rf[i];
        sum += rf[i];
      end
    end
    Start = 1'b1;
    Dir = d;
    BaseAddr = b;
    @(posedge Clk);
    #1;
    done_cyc = 0;
    busy_cnt = 0;
    bad = 0;
    last = chain ? N + 1 : N + 3;
    for (int c = 1; c <= last; c++) begin
      Dir = 1'($urandom);
      BaseAddr = 8'($urandom);
      Start = 1'b0;
      if (c == poke) begin
        Start = 1'b1;
        Dir = ~d;
      end
      if (chain && c == N + 1) begin
        Start = 1'b1;
        Dir = nd;
        BaseAddr = nb;
      end
      @(negedge Clk);
      if (Busy === 1'b1) busy_cnt++;
      if (c <= N) begin
        a = b + M'(c - 1);
        if (Busy !== 1'b1 || MemAddr !== a ||
            MemWriteEn !== !d || RfWriteEn !== d) bad++;
      end else if (MemWriteEn !== 1'b0 || RfWriteEn !== 1'b0 ||
                   MemAddr !== '0) begin
        bad++;
      end
      if (Done === 1'b1) done_cyc = (done_cyc == 0) ? c : -1;
`ifdef RSF_CHECKSUM_EN
      if (c == 1) chk({tag, "_cksum_clear"}, Checksum, 0);
      if (c == N + 1) cs = Checksum;
`endif
      if (!(chain && c == N + 1)) begin
        @(posedge Clk);
        #1;
      end
    end
    if (!chain) Start = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, N + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, N);
    chk({tag, "_cycle_seq"}, bad, 0);
`ifdef RSF_CHECKSUM_EN
    chk({tag, "_checksum"}, cs, sum);
`else
    if (cs !== sum) cs = sum;
`endif
  endtask

  initial begin
    int bad;
    logic d;
    logic [M-1:0] b;
    for (int i = 0; i < N; i++) begin
      rf[i] = 8'($urandom);
      exp_rf[i] = rf[i];
    end
    for (int i = 0; i < D; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end

    // Reset with Start held high
    Reset = 1'b1;
    Start = 1'b1;
    Dir = 1'b0;
    BaseAddr = 8'h10;
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_rfwe", RfWriteEn, 0);
    chk("rst_memwe", MemWriteEn, 0);
    chk("rst_memaddr", MemAddr, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    chk("post_rst_busy", Busy, 0);
    chk("post_rst_memwe", MemWriteEn, 0);
    @(posedge Clk);
    #1;
    cmp_images("rst");

    // Directed spill
    rf[0] = 8'h11;
    rf[1] = 8'h22;
    rf[2] = 8'h33;
    rf[3] = 8'h44;
    for (int i = 0; i < N; i++) exp_rf[i] = rf[i];
    do_op("spill", 1'b0, 8'h10, 0, 1'b0, 1'b0, 8'h00);
    chk("spill_mem13", mem[8'h13], 8'h44);
    cmp_images("spill");

    // Fill across the memory wrap
    mem[8'hFE] = 8'hA0;
    mem[8'hFF] = 8'hA1;
    mem[8'h00] = 8'hA2;
    mem[8'h01] = 8'hA3;
    exp_mem[8'hFE] = 8'hA0;
    exp_mem[8'hFF] = 8'hA1;
    exp_mem[8'h00] = 8'hA2;
    exp_mem[8'h01] = 8'hA3;
    do_op("fillwrap", 1'b1, 8'hFE, 0, 1'b0, 1'b0, 8'h00);
    chk("fillwrap_r3", rf[3], 8'hA3);
    cmp_images("fillwrap");

    // Start with Dir=1 during cycle 2 of a spill is ignored
    do_op("ignore", 1'b0, 8'h40, 2, 1'b0, 1'b0, 8'h00);
    cmp_images("ignore");

    // Start held through the Done cycle chains a fill
    do_op("chain1", 1'b0, 8'h60, 0, 1'b1, 1'b1, 8'h80);
    do_op("chain2", 1'b1, 8'h80, 0, 1'b0, 1'b0, 8'h00);
    cmp_images("chain");

    // Reset at the edge ending cycle 2 of a spill
    for (int i = 0; i < N; i++) begin
      rf[i] = 8'($urandom);
      exp_rf[i] = rf[i];
    end
    exp_mem[8'h20] = rf[0];
    exp_mem[8'h21] = rf[1];
    Start = 1'b1;
    Dir = 1'b0;
    BaseAddr = 8'h20;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("midrst_busy", Busy, 0);
    chk("midrst_memwe", MemWriteEn, 0);
    chk("midrst_rfwe", RfWriteEn, 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) bad++;
      @(negedge Clk);
    end
    chk("midrst_quiet", bad, 0);
    @(posedge Clk);
    #1;
    cmp_images("midrst");
    do_op("after_rst", 1'b0, 8'h20, 0, 1'b0, 1'b0, 8'h00);
    cmp_images("after_rst");

`ifdef RSF_CHECKSUM_EN
    rf[0] = 8'h80;
    rf[1] = 8'h90;
    rf[2] = 8'h70;
    rf[3] = 8'h05;
    for (int i = 0; i < N; i++) exp_rf[i] = rf[i];
    do_op("cksum", 1'b0, 8'hC0, 0, 1'b0, 1'b0, 8'h00);
    chk("cksum_hold", Checksum, 8'h85);
    do_op("cksum2", 1'b1, 8'h30, 0, 1'b0, 1'b0, 8'h00);
`endif

    // Randomized transfers against the reference images
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 0) begin
        for (int i = 0; i < N; i++) begin
          rf[i] = 8'($urandom);
          exp_rf[i] = rf[i];
        end
      end
      d = 1'($urandom);
      b = 8'($urandom);
      do_op("rand", d, b, 0, 1'b0, 1'b0, 8'h00);
      cmp_images("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_spill_fill.md
Name: reg_spill_fill

Overview:
- Sequencer that acts as the master on the register file's read and write ports.
- Spill: bulk-copies all 2**A registers into data memory starting at a base address. Fill: restores them from memory.
- Used for context save/restore and for bench preload/dump.
- Sits between the controller, the register file (combinational read, clocked write) and data memory (combinational read, clocked write).

Parameters:
- W, 8, data path width (register and memory word).
- A, 2, register address width; 2**A registers are transferred.
- M, 8, data memory address width.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a transfer; sampled only in IDLE.
- Dir  input  1  0 = spill (regs to mem), 1 = fill (mem to regs); latched with Start.
- BaseAddr  input  M  first memory address; latched with Start.
- RfRaddr  output  A  register file read address (spill).
- RfDataOut  input  W  register file read data for RfRaddr.
- RfWriteEn  output  1  register file write enable (fill).
- RfWaddr  output  A  register file write address.
- RfDataIn  output  W  register file write data.
- MemAddr  output  M  data memory address.
- MemWriteEn  output  1  data memory write enable (spill).
- MemDataIn  output  W  data memory write data.
- MemDataOut  input  W  data memory read data for MemAddr.
- Busy  output  1  high while transferring.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- State registers: state (IDLE, XFER), index counter (A bits), dir_q, base_q (M bits), Done register.
- Reset: state=IDLE, index=0, dir_q=0, base_q=0, Done=0. Busy, RfWriteEn and MemWriteEn are 0. All address and data outputs are 0.
- IDLE + Start=1 at edge E0: latch Dir and BaseAddr, index=0, go to XFER. Busy is high from E0 onward.
- IDLE + Start=0: remain IDLE. Strobes stay 0.
- In XFER each cycle transfers register `index`:
  - MemAddr = (base_q + index) mod 2**M, zero-extending index. Wrap past 2**M-1 to 0 is required; no error.
  - Spill (dir_q=0): RfRaddr=index, MemDataIn=RfDataOut, MemWriteEn=1, RfWriteEn=0.
  - Fill (dir_q=1): RfWaddr=index, RfDataIn=MemDataOut, RfWriteEn=1, MemWriteEn=0.
  - Strobes and addresses are combinational from registered state, index and dir_q. No combinational path from Start to any strobe.
- index increments each XFER edge.
- When index == 2**A-1 at an edge: go to IDLE, index=0, Done=1 for exactly the next cycle.
- Latency: N=2**A write cycles. Start edge E0; transfers occur in cycles 1..N; Done high in cycle N+1; Busy low in cycle N+1.
- Start while Busy: ignored, not queued.
- Start coincident with the Done cycle: accepted, since state is IDLE. Done and the new Busy overlap for that cycle.
- Dir and BaseAddr changes during XFER: no effect.
- Outside XFER: RfRaddr, RfWaddr, MemAddr, RfDataIn and MemDataIn drive 0; both write enables are 0.
- Reset mid-transfer: at the reset edge, return to IDLE with all reset values. No write strobe is asserted in the cycle following reset. Done is not pulsed. A partial transfer is acceptable.
- Reset has priority over Start.

Optional Feature:
- Macro: RSF_CHECKSUM_EN.
- Defined:
  - Adds output Checksum (W bits). It is the mod-2**W sum of every word transferred in the current or last operation: MemDataIn on spill, RfDataIn on fill.
  - Cleared to 0 on Reset and on each accepted Start. Stable and valid while Done=1 and afterwards until the next Start.
- Undefined: port and accumulator are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: assert Reset 2 cycles with Start=1 -> Busy=0, Done=0, RfWriteEn=0, MemWriteEn=0, MemAddr=0; no memory or register writes.
- Spill: regs = {0x11,0x22,0x33,0x44}, Start with Dir=0, BaseAddr=0x10 -> mem[0x10..0x13] = 0x11,0x22,0x33,0x44. Done pulses exactly in cycle 5 after the Start edge. Busy high for cycles 1-4.
- Fill wrap: mem[0xFE]=0xA0, mem[0xFF]=0xA1, mem[0x00]=0xA2, mem[0x01]=0xA3; Start with Dir=1, BaseAddr=0xFE -> r0..r3 = 0xA0..0xA3. MemAddr sequence FE, FF, 00, 01.
- Busy/back-to-back: Start with Dir=1 asserted in cycle 2 of a spill -> ignored, spill completes unchanged. Start held through the Done cycle -> second operation begins immediately with Done and Busy overlapping one cycle.
- Reset mid-transfer: Reset at the edge ending cycle 2 of a spill to base 0x20 -> only mem[0x20] and mem[0x21] written. IDLE afterwards, Done never pulses, next Start runs a full spill.
- RSF_CHECKSUM_EN: spill of {0x80,0x90,0x70,0x05} -> Checksum=0x85 during Done. A following Start clears it to 0 before accumulating.
